chacha_xor: RTL
===============

Name: chacha_xor

Overview:
- Keystream consumer directly downstream of the ChaCha block core.
- Pops keystream bytes from the core's byte read port and XORs them with a valid/ready message byte stream.
- Emits ciphertext/plaintext through a registered output stage.
- Tracks keystream usage per block and raises a level request for a fresh block when the current one is exhausted or a message ends.

Parameters:
BLOCK_BYTES, 64, keystream bytes per block; power of two, 2..64
CNT_W, 16, width of the blocks-consumed counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ks_ready  input  1  core ready: keystream block valid, ks_data is current byte
ks_data  input  8  current keystream byte from core
ks_read  output  1  one-cycle pop strobe to core; core advances to next byte on the following cycle
blk_req  output  1  level request for new block; the upstream loader rewrites the core while this is high
in_valid  input  1  message byte valid
in_data  input  8  message byte
in_last  input  1  final byte of message
in_ready  output  1  message byte accepted this cycle when in_valid & in_ready
out_valid  output  1  result byte valid
out_data  output  8  in_data XOR ks_data
out_last  output  1  copy of in_last for this byte
out_ready  input  1  downstream accepts result
blk_count  output  CNT_W  keystream blocks retired since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at a clock edge, any state, mid-block included):
  - state=EMPTY, byte_cnt=0, blk_count=0, out_valid=0, out_data=0, out_last=0.
  - ks_read=0, in_ready=0; blk_req=1 (combinational from EMPTY).
  - Stale keystream in the core after reset is never used.
- States:
  - EMPTY: blk_req=1. Waits for ks_ready==0 (core being rewritten), then goes to FILL.
  - FILL: blk_req=0. Waits for ks_ready==1, then goes to STREAM.
  - STREAM: bytes transfer.
- A ks_ready drop and rise in consecutive cycles is legal; each transition takes exactly one cycle.
- In STREAM:
  - in_ready = ks_ready & (!out_valid | out_ready).
  - fire = in_valid & in_ready; ks_read = fire (combinational, never high outside STREAM).
  - On fire: out_data <= in_data ^ ks_data, out_last <= in_last, out_valid <= 1, byte_cnt <= byte_cnt+1.
- Exit from STREAM: on fire with byte_cnt==BLOCK_BYTES-1 or in_last=1:
  - byte_cnt <= 0, blk_count <= blk_count+1, state <= EMPTY.
  - Unused keystream after in_last is discarded, never reused.
- Output register:
  - Cleared (out_valid<=0) when out_valid & out_ready & !fire.
  - A simultaneous pop and fire reloads it with no bubble.
- Latency: one cycle from accepted input to out_valid.
- Throughput: one byte/clock while out_ready=1 within a block; 2+ cycles lost per block boundary plus core recompute time.
- Stall behaviour:
  - out_valid=1 & out_ready=0: in_ready=0; out_data and out_last hold stable.
  - ks_ready low while in STREAM (protocol error): in_ready=0, no pop, state held.
- in_valid, in_data and in_last are ignored unless fire.
- out_valid draining is independent of state; the last byte of a block still drains while in EMPTY/FILL.
- byte_cnt width = log2(BLOCK_BYTES); never wraps, since exit resets it.

Test Plan:
- Reset then core idle (ks_ready=1): blk_req=1 and in_ready=0 until ks_ready pulses low then high; after that 1 cycle in FILL, then STREAM with blk_req=0.
- Stream 64 bytes, in_data=0x00, keystream 0x00..0x3F, out_ready=1: out_data=0x00..0x3F back-to-back, latency 1; ks_read high for 64 cycles; blk_count=1, state EMPTY, blk_req=1 after byte 63.
- 5-byte message, in_last on byte 5, in_data=0xFF, ks=0x10..0x14: out_data=0xEF,0xEE,0xED,0xEC,0xEB; out_last only on 5th; enters EMPTY with byte_cnt=0; next message uses a fresh block.
- Back-pressure: out_ready=0 for 3 cycles mid-block: in_ready=0, ks_read=0, out_data stable; on release, no byte lost or duplicated (byte_cnt sequence continuous).
- Reset asserted at byte 30 of a block: next cycle out_valid=0, blk_count=0, blk_req=1; the following keystream comes only after a ks_ready low/high cycle.
- blk_count wrap with CNT_W=2: 5 single-byte messages → blk_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/chacha_xor.sv
// chacha_xor: XORs a valid/ready message byte stream with keystream bytes
// popped from the ChaCha core's byte read port. Each keystream block is used
// once: the block is retired when all BLOCK_BYTES bytes are consumed or when a
// message ends, and a fresh block is requested through blk_req.
//
// Handshake: a message byte moves when in_valid & in_ready at a rising edge,
// and a result byte moves when out_valid & out_ready at a rising edge.
// in_valid/in_data/in_last are only looked at on such a transfer, and a held
// result keeps out_data/out_last stable until it is taken.
//
// dbg_state encoding: 0 = EMPTY (blk_req high), 1 = FILL, 2 = STREAM.
module chacha_xor #(
  parameter int BLOCK_BYTES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ks_ready,
  input  logic [7:0]       ks_data,
  output logic             ks_read,
  output logic             blk_req,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] blk_count,
  output logic [1:0]       dbg_state
);

  localparam int BC_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t          state;
  logic [BC_W-1:0] byte_cnt;
  logic            fire;
  logic            blk_done;

  // Handshake decode: bytes only move in STREAM with a live block and room in
  // the output register (empty, or being drained this cycle).
  always_comb begin
    blk_req   = (state == ST_EMPTY);
    in_ready  = (state == ST_STREAM) && ks_ready && (!out_valid || out_ready);
    fire      = in_valid && in_ready;
    ks_read   = fire;
    blk_done  = fire && ((byte_cnt == LAST_IDX) || in_last);
    dbg_state = state;
  end

  // Block-tracking FSM plus the output register; draining is independent of
  // state so the final byte of a block leaves while the core is reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      byte_cnt  <= '0;
      blk_count <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      case (state)
        // Wait for the core to drop ready, proving it is being rewritten,
        // so stale keystream is never consumed.
        ST_EMPTY: begin
          if (!ks_ready) state <= ST_FILL;
        end
        ST_FILL: begin
          if (ks_ready) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (blk_done) begin
            byte_cnt  <= '0;
            blk_count <= blk_count + CNT_W'(1);
            state     <= ST_EMPTY;
          end else if (fire) begin
            byte_cnt <= byte_cnt + BC_W'(1);
          end
        end
        default: state <= ST_EMPTY;
      endcase

      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ ks_data;
        out_last  <= in_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
